uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Drains the command-response FIFO and feeds the UART transmitter, one byte per frame.
//  Sits in the UART clock domain between the async FIFO read port and UART_TX.
//  Result bytes come from the system controller (register reads, ALU results).
//  Enforces an optional inter-frame gap, detects a stalled transmitter, and counts sent bytes.
// PARAMETERS
//  DATA_WIDTH   8    width of FIFO data and TX parallel data
//  GAP_CYCLES   0    idle CLK cycles forced between frames (0 = back-to-back)
//  ACK_TIMEOUT  64   CLK cycles to wait for TX_BUSY rise before aborting (>=2)
//  CNT_WIDTH    16   width of BYTE_CNT
// PORTS
//  CLK            in   1           UART-domain clock
//  RST            in   1           asynchronous, active-low reset
//  TX_EN          in   1           1 = fetch new bytes; 0 = finish current byte, fetch none
//  FIFO_EMPTY     in   1           FIFO read-side empty flag (synchronised)
//  FIFO_RD_DATA   in   DATA_WIDTH  FIFO head word, first-word fall-through
//  FIFO_RD_INC    out  1           one-cycle pop pulse
//  TX_BUSY        in   1           UART_TX frame in progress
//  TX_P_DATA      out  DATA_WIDTH  byte presented to UART_TX
//  TX_DATA_VALID  out  1           TX_P_DATA valid, held until TX_BUSY seen high
//  ERR_CLR        in   1           clears TX_ERR
//  TX_ERR         out  1           sticky: ACK_TIMEOUT expired
//  BYTE_CNT       out  CNT_WIDTH   frames completed, wraps to 0
//  FEEDER_IDLE    out  1           1 when in IDLE
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values:
//    - FIFO_RD_INC = 0, TX_DATA_VALID = 0, TX_ERR = 0.
//    - TX_P_DATA = 0, BYTE_CNT = 0.
//    - FEEDER_IDLE = 1, state = IDLE.
//  - IDLE:
//    - If TX_EN & !FIFO_EMPTY: next edge loads TX_P_DATA <= FIFO_RD_DATA, FIFO_RD_INC <= 1 and TX_DATA_VALID <= 1, then goes to LOAD.
//    - Otherwise stays in IDLE.
//  - LOAD:
//    - FIFO_RD_INC is high for exactly the first LOAD cycle.
//    - TX_P_DATA is stable for the whole LOAD state.
//    - On TX_BUSY=1: TX_DATA_VALID <= 0, go to WAIT_DONE.
//    - The timer counts LOAD cycles. When it reaches ACK_TIMEOUT with no busy: TX_DATA_VALID <= 0, TX_ERR <= 1, go to IDLE. The byte is dropped and BYTE_CNT is unchanged.
//  - WAIT_DONE:
//    - On TX_BUSY=0: BYTE_CNT <= BYTE_CNT+1 (mod 2^CNT_WIDTH).
//    - Then go to GAP if GAP_CYCLES>0, else IDLE.
//  - GAP: stays exactly GAP_CYCLES cycles, then goes to IDLE. No fetch happens during GAP.
//  - Latency: FIFO non-empty in IDLE -> TX_DATA_VALID high on the next edge (1 cycle).
//  - Back-to-back throughput: at most 1 byte per UART frame + 1 + GAP_CYCLES cycles.
//  - FIFO_EMPTY is sampled only in IDLE. No pop is ever issued while FIFO_EMPTY=1.
//  - TX_EN falling mid-byte: the current byte completes normally, then the block stays in IDLE.
//  - ERR_CLR and a timeout in the same cycle: set wins, so TX_ERR = 1.
//  - ERR_CLR does not change the state.
//  - TX_BUSY already high when LOAD is entered counts as the acknowledge.
//  - Async reset mid-frame: all registers return to reset values immediately. A popped byte not yet sent is lost; this is accepted.
// STRUCTURE
//  - Shared package/include (uart_sys_pkg):
//    - feeder state encodings: IDLE, LOAD, WAIT_DONE, GAP as 2-bit localparams.
//    - DATA_WIDTH default.
//  - Sub-module tx_feeder_timer:
//    - Loadable down-counter of width clog2(max(GAP_CYCLES, ACK_TIMEOUT)+1).
//    - Ports: load, load_val, expired.
//    - Shared between the GAP and ACK-timeout functions.
//  - FSM, data register and byte counter live in uart_tx_feeder.
// TESTING
//  1. Reset, FIFO holds 0xA5, TX_EN=1:
//     - 1 cycle later TX_P_DATA=0xA5, VALID=1, RD_INC pulses once.
//     - Model busy 10 cycles -> BYTE_CNT=1, FEEDER_IDLE=1.
//  2. FIFO holds 0x11, 0x22, 0x33, GAP_CYCLES=4:
//     - Bytes are sent in order, 3 RD_INC pulses total.
//     - At least 4 idle cycles between busy fall and the next VALID; BYTE_CNT=3.
//  3. TX_BUSY held 0, ACK_TIMEOUT=64:
//     - VALID drops after 64 cycles, TX_ERR=1, BYTE_CNT=0, no second pop.
//     - Pulse ERR_CLR -> TX_ERR=0.
//  4. TX_EN dropped during WAIT_DONE with 2 bytes still queued:
//     - Current byte completes (BYTE_CNT+1), then no RD_INC while TX_EN=0.
//     - Re-enable -> remaining bytes are sent.
//  5. RST asserted while in LOAD:
//     - All outputs return to reset values at once, FIFO_EMPTY=1 is honoured, no spurious pop.
//  6. BYTE_CNT preset near wrap (CNT_WIDTH=4, 16 frames): counter wraps 15 -> 0 without stalling.

Source files
------------

// File: rtl/uart_sys_pkg.sv
// Shared UART-subsystem definitions: feeder state encodings, default data width
// and the sizing helper for the feeder's shared down-counter.
package uart_sys_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LOAD      = ST_LOAD,
        WAIT_DONE = ST_WAIT_DONE,
        GAP       = ST_GAP
    } feeder_state_e;

    // Counter must hold the larger of the two reload values.
    function automatic int feeder_timer_width(input int gap_cycles, input int ack_timeout);
        int max_val;
        max_val = (gap_cycles > ack_timeout) ? gap_cycles : ack_timeout;
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tx_feeder_timer.sv
// Loadable down-counter that saturates at zero; used by the feeder both for the
// acknowledge timeout in LOAD and for the inter-frame gap.
module tx_feeder_timer #(
    parameter int WIDTH = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Pops result bytes from the command-response FIFO and hands them to UART_TX one
// frame at a time, with optional inter-frame gap, ack timeout and a frame counter.
module uart_tx_feeder
    import uart_sys_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int GAP_CYCLES  = 0,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TX_EN,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    input  logic                  ERR_CLR,
    output logic                  TX_ERR,
    output logic [CNT_WIDTH-1:0]  BYTE_CNT,
    output logic                  FEEDER_IDLE
);

    localparam int TW = feeder_timer_width(GAP_CYCLES, ACK_TIMEOUT);
    // Reload with N-1: the counter is sampled on the edge that closes cycle N.
    localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    feeder_state_e         state_q,  state_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic                  valid_q,  valid_d;
    logic                  rd_inc_q, rd_inc_d;
    logic                  err_q,    err_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
    logic                  idle_q,   idle_d;

    logic                  timer_load;
    logic [TW-1:0]         timer_val;
    logic                  timer_expired;

    tx_feeder_timer #(
        .WIDTH (TW)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        rd_inc_d   = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        timer_load = 1'b0;
        timer_val  = ACK_LOAD;

        // A timeout below overrides this clear in the same cycle.
        if (ERR_CLR) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (TX_EN && !FIFO_EMPTY) begin
                    data_d     = FIFO_RD_DATA;
                    rd_inc_d   = 1'b1;
                    valid_d    = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = ACK_LOAD;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (TX_BUSY) begin
                    valid_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (timer_expired) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (GAP_CYCLES > 0) begin
                        timer_load = 1'b1;
                        timer_val  = GAP_LOAD;
                        state_d    = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (timer_expired) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        idle_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            data_q   <= '0;
            valid_q  <= 1'b0;
            rd_inc_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            rd_inc_q <= rd_inc_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
        end
    end

    assign TX_P_DATA     = data_q;
    assign TX_DATA_VALID = valid_q;
    assign FIFO_RD_INC   = rd_inc_q;
    assign TX_ERR        = err_q;
    assign BYTE_CNT      = cnt_q;
    assign FEEDER_IDLE   = idle_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-backed FIFO, randomised UART_TX responder and a
// transaction-level model of the feeder compared against the outputs every cycle.
module tb_uart_tx_feeder;

    localparam int DW  = 8;
    localparam int GAP = 4;
    localparam int ACK = 64;
    localparam int CW  = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          TX_EN = 1'b0;
    logic          FIFO_EMPTY = 1'b1;
    logic [DW-1:0] FIFO_RD_DATA = '0;
    logic          FIFO_RD_INC;
    logic          TX_BUSY = 1'b0;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_DATA_VALID;
    logic          ERR_CLR = 1'b0;
    logic          TX_ERR;
    logic [CW-1:0] BYTE_CNT;
    logic          FEEDER_IDLE;

    uart_tx_feeder #(
        .DATA_WIDTH  (DW),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (ACK),
        .CNT_WIDTH   (CW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .TX_EN         (TX_EN),
        .FIFO_EMPTY    (FIFO_EMPTY),
        .FIFO_RD_DATA  (FIFO_RD_DATA),
        .FIFO_RD_INC   (FIFO_RD_INC),
        .TX_BUSY       (TX_BUSY),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .ERR_CLR       (ERR_CLR),
        .TX_ERR        (TX_ERR),
        .BYTE_CNT      (BYTE_CNT),
        .FEEDER_IDLE   (FEEDER_IDLE)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] fifo_q[$];
    bit uart_on    = 1'b1;
    int uart_len   = 0;
    bit pending    = 1'b0;
    int delay_left = 0;
    int busy_left  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    task automatic fifo_refresh();
        FIFO_EMPTY   = (fifo_q.size() == 0);
        FIFO_RD_DATA = FIFO_EMPTY ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        fifo_refresh();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!TX_DATA_VALID) begin
            if (n == 10) begin expire(name); break; end
            n++;
            tick();
        end
    endtask

    task automatic wait_idle(input int budget, output int pops);
        int n = 0;
        pops = 0;
        while (!(fifo_q.size() == 0 && FEEDER_IDLE && !TX_BUSY && !pending)) begin
            if (n == budget) begin expire("wait_idle"); break; end
            n++;
            tick();
            if (FIFO_RD_INC) pops++;
        end
    endtask

    // FIFO read side and UART_TX responder, both moving on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST && FIFO_RD_INC && fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_refresh();
            if (!RST) begin
                TX_BUSY = 1'b0;
                pending = 1'b0;
                busy_left = 0;
            end else if (TX_BUSY) begin
                busy_left--;
                if (busy_left == 0) TX_BUSY = 1'b0;
            end else begin
                if (!pending && uart_on && TX_DATA_VALID) begin
                    pending = 1'b1;
                    delay_left = $urandom_range(0, 2);
                end
                if (pending) begin
                    if (delay_left == 0) begin
                        TX_BUSY = 1'b1;
                        busy_left = (uart_len != 0) ? uart_len : $urandom_range(1, 10);
                        pending = 1'b0;
                    end else begin
                        delay_left--;
                    end
                end
            end
        end
    end

    // Reference model: the feeder as a sequence of transactions (fetch, wait for
    // acknowledge or give up, wait for the frame to end, rest) driven only by the
    // inputs seen on each edge.
    bit            m_valid = 1'b0;
    bit            m_wait  = 1'b0;
    int            m_gap   = 0;
    int            m_age   = 0;
    int            m_cnt   = 0;
    bit            m_err   = 1'b0;
    logic [DW-1:0] m_byte  = '0;

    initial begin
        bit exp_rd;
        bit tmo;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST) begin
                m_valid = 1'b0; m_wait = 1'b0; m_gap = 0; m_age = 0;
                m_cnt = 0; m_err = 1'b0; m_byte = '0;
                exp_rd = 1'b0;
            end else begin
                exp_rd = 1'b0;
                tmo = 1'b0;
                if (m_valid) begin
                    if (TX_BUSY) begin
                        m_valid = 1'b0; m_wait = 1'b1;
                    end else if (m_age == ACK) begin
                        m_valid = 1'b0; tmo = 1'b1;
                    end else begin
                        m_age++;
                    end
                end else if (m_wait) begin
                    if (!TX_BUSY) begin
                        m_wait = 1'b0;
                        m_cnt = (m_cnt + 1) % (1 << CW);
                        m_gap = GAP;
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else if (TX_EN && fifo_q.size() > 0) begin
                    exp_rd = 1'b1; m_valid = 1'b1; m_age = 1; m_byte = fifo_q[0];
                end
                if (tmo) m_err = 1'b1;
                else if (ERR_CLR) m_err = 1'b0;
            end
            check("rd_inc",   32'(FIFO_RD_INC),   32'(exp_rd));
            check("valid",    32'(TX_DATA_VALID), 32'(m_valid));
            check("p_data",   32'(TX_P_DATA),     32'(m_byte));
            check("byte_cnt", 32'(BYTE_CNT),      32'(m_cnt));
            check("tx_err",   32'(TX_ERR),        32'(m_err));
            check("idle",     32'(FEEDER_IDLE),   32'(!m_valid && !m_wait && m_gap == 0));
        end
    end

    initial begin
        int pops;
        int n;

        // Reset
        repeat (3) tick();
        check("rst_valid", 32'(TX_DATA_VALID), 32'd0);
        check("rst_idle",  32'(FEEDER_IDLE),   32'd1);
        RST = 1'b1;
        tick();

        // Single byte, fixed 10-cycle frame
        uart_len = 10;
        push(8'hA5);
        TX_EN = 1'b1;
        tick();
        check("t1_rd_inc", 32'(FIFO_RD_INC),   32'd1);
        check("t1_valid",  32'(TX_DATA_VALID), 32'd1);
        check("t1_data",   32'(TX_P_DATA),     32'hA5);
        tick();
        check("t1_rd_once", 32'(FIFO_RD_INC), 32'd0);
        wait_idle(200, pops);
        check("t1_cnt", 32'(BYTE_CNT), 32'd1);

        // Three queued bytes with the inter-frame gap
        uart_len = 0;
        push(8'h11); push(8'h22); push(8'h33);
        wait_idle(400, pops);
        check("t2_pops", 32'(pops),     32'd3);
        check("t2_cnt",  32'(BYTE_CNT), 32'd4);

        // Transmitter never acknowledges
        uart_on = 1'b0;
        push(8'h5A);
        wait_valid("t3_valid_rise");
        n = 0;
        while (TX_DATA_VALID && n < 200) begin n++; tick(); end
        check("t3_valid_len", 32'(n),            32'd64);
        check("t3_err",       32'(TX_ERR),       32'd1);
        check("t3_cnt",       32'(BYTE_CNT),     32'd4);
        check("t3_fifo",      32'(fifo_q.size()), 32'd0);
        repeat (3) tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("t3_err_clr", 32'(TX_ERR), 32'd1 - 32'd1);

        // Timeout while ERR_CLR is held: the set must win on that edge
        ERR_CLR = 1'b1;
        push(8'h5B);
        wait_valid("t3b_valid_rise");
        n = 0;
        while (TX_DATA_VALID && n < 200) begin n++; tick(); end
        check("t3b_set_wins", 32'(TX_ERR), 32'd1);
        tick();
        check("t3b_cleared", 32'(TX_ERR), 32'd0);
        ERR_CLR = 1'b0;

        // TX_EN dropped while a frame is on the line
        uart_on = 1'b1;
        uart_len = 8;
        push(8'h66); push(8'h77); push(8'h88);
        n = 0;
        while (!TX_BUSY && n < 20) begin n++; tick(); end
        if (!TX_BUSY) expire("t4_busy");
        TX_EN = 1'b0;
        repeat (40) tick();
        check("t4_fifo_held", 32'(fifo_q.size()), 32'd2);
        check("t4_cnt_one",   32'(BYTE_CNT),     32'd5);
        TX_EN = 1'b1;
        wait_idle(400, pops);
        check("t4_pops", 32'(pops),     32'd2);
        check("t4_cnt",  32'(BYTE_CNT), 32'd7);

        // Asynchronous reset while waiting in LOAD
        uart_on = 1'b0;
        uart_len = 0;
        push(8'h99);
        wait_valid("t5_valid_rise");
        repeat (2) tick();
        RST = 1'b0;
        #1;
        check("t5_valid",  32'(TX_DATA_VALID), 32'd0);
        check("t5_rd_inc", 32'(FIFO_RD_INC),   32'd0);
        check("t5_err",    32'(TX_ERR),        32'd0);
        check("t5_data",   32'(TX_P_DATA),     32'd0);
        check("t5_cnt",    32'(BYTE_CNT),      32'd0);
        check("t5_idle",   32'(FEEDER_IDLE),   32'd1);
        repeat (3) tick();
        RST = 1'b1;
        uart_on = 1'b1;
        repeat (10) tick();
        check("t5_cnt_after", 32'(BYTE_CNT),    32'd0);
        check("t5_idle_after", 32'(FEEDER_IDLE), 32'd1);

        // Sixteen frames wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) push(DW'($urandom_range(0, 255)));
        wait_idle(3000, pops);
        check("t6_pops", 32'(pops),     32'd16);
        check("t6_wrap", 32'(BYTE_CNT), 32'd0);

        // Random traffic, enables, clears and silent-transmitter episodes
        for (int i = 0; i < 600; i++) begin
            tick();
            if ($urandom_range(0, 99) < 30 && fifo_q.size() < 8) push(DW'($urandom_range(0, 255)));
            TX_EN   = ($urandom_range(0, 99) < 85);
            ERR_CLR = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 3) uart_on = !uart_on;
        end
        uart_on = 1'b1;
        TX_EN   = 1'b1;
        ERR_CLR = 1'b0;
        wait_idle(3000, pops);
        check("final_fifo", 32'(fifo_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
